// File: rtl/hardtanh_backward.sv
// rtl/hardtanh_backward.sv - hardtanh gradient mask joining saved-x and upstream-grad streams
// Optional: define HARDTANH_BWD_CLIP_COUNT_EN to add the per-tensor clip_count output.
module hardtanh_backward #(
  parameter int MAX_VAL                     = 64,
  parameter int MIN_VAL                     = -64,
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int GRAD_PRECISION_0            = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  input  logic [GRAD_PRECISION_0-1:0]      grad_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic                             grad_in_0_valid,
  output logic                             grad_in_0_ready,
  output logic [GRAD_PRECISION_0-1:0]      grad_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  output logic                             grad_out_0_valid,
  input  logic                             grad_out_0_ready,
`ifdef HARDTANH_BWD_CLIP_COUNT_EN
  output logic                             grad_out_0_last,
  output logic [$clog2(DATA_IN_0_TENSOR_SIZE_DIM_0*DATA_IN_0_TENSOR_SIZE_DIM_1+1)-1:0] clip_count
`else
  output logic                             grad_out_0_last
`endif
);

  localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int BEATS = (DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0) *
                         (DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW    = GRAD_PRECISION_0;

  // Bounds are compared on raw integers, so the fraction width only has to be sane.
  if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_frac_check
    $error("hardtanh_backward: fractional bits exceed total width of x");
  end

  logic [N-1:0]  pass;
  logic [GW-1:0] masked    [N];
  logic [GW-1:0] main_data [N];
  logic [GW-1:0] skid_data [N];
  logic          main_valid, main_last;
  logic          skid_valid, skid_last;
  logic          accept, beat_last;
  logic [CW-1:0] beat_cnt;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pass[i]   = (32'($signed(data_in_0[i])) > MIN_VAL) &&
                  (32'($signed(data_in_0[i])) < MAX_VAL);
      masked[i] = pass[i] ? grad_in_0[i] : '0;
    end
  end

  // Readies are gated by rst so both streams see back-pressure while in reset.
  assign data_in_0_ready = rst && grad_in_0_valid && !skid_valid;
  assign grad_in_0_ready = rst && data_in_0_valid && !skid_valid;
  assign accept          = data_in_0_valid && grad_in_0_valid && !skid_valid;
  assign beat_last       = (beat_cnt == CW'(BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_last ? '0 : beat_cnt + CW'(1);
    end
  end

`ifdef HARDTANH_BWD_CLIP_COUNT_EN
  localparam int CCW = $clog2(DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1 + 1);
  logic [CCW-1:0] beat_clips, clip_acc, clip_total, main_clip, skid_clip;

  always_comb begin
    beat_clips = '0;
    for (int i = 0; i < N; i++) begin
      beat_clips = beat_clips + CCW'(!pass[i]);
    end
  end

  // Each beat carries the running total, so the last beat holds the full tensor count.
  assign clip_total = clip_acc + beat_clips;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clip_acc <= '0;
    end else if (accept) begin
      clip_acc <= beat_last ? '0 : clip_total;
    end
  end

  assign clip_count = main_clip;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_last  <= 1'b0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        main_data[i] <= '0;
        skid_data[i] <= '0;
      end
`ifdef HARDTANH_BWD_CLIP_COUNT_EN
      main_clip <= '0;
      skid_clip <= '0;
`endif
    end else if (skid_valid) begin
      // Skid full implies main full and no accept this cycle.
      if (grad_out_0_ready) begin
        main_data  <= skid_data;
        main_last  <= skid_last;
        skid_valid <= 1'b0;
`ifdef HARDTANH_BWD_CLIP_COUNT_EN
        main_clip  <= skid_clip;
`endif
      end
    end else if (accept) begin
      if (!main_valid || grad_out_0_ready) begin
        main_valid <= 1'b1;
        main_data  <= masked;
        main_last  <= beat_last;
`ifdef HARDTANH_BWD_CLIP_COUNT_EN
        main_clip  <= clip_total;
`endif
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= masked;
        skid_last  <= beat_last;
`ifdef HARDTANH_BWD_CLIP_COUNT_EN
        skid_clip  <= clip_total;
`endif
      end
    end else if (grad_out_0_ready) begin
      main_valid <= 1'b0;
    end
  end

  assign grad_out_0       = main_data;
  assign grad_out_0_valid = main_valid;
  assign grad_out_0_last  = main_last;

endmodule

// File: tb/tb_hardtanh_backward.sv
// tb/tb_hardtanh_backward.sv - self-checking bench for hardtanh_backward
module tb_hardtanh_backward;

  localparam int N     = 2;
  localparam int XW    = 8;
  localparam int GW    = 8;
  localparam int BEATS = 4;
  localparam int MAXV  = 64;
  localparam int MINV  = -64;

  logic          clk = 1'b0;
  logic          rst;
  logic [XW-1:0] data_in_0 [N];
  logic          data_in_0_valid;
  logic          data_in_0_ready;
  logic [GW-1:0] grad_in_0 [N];
  logic          grad_in_0_valid;
  logic          grad_in_0_ready;
  logic [GW-1:0] grad_out_0 [N];
  logic          grad_out_0_valid;
  logic          grad_out_0_ready;
  logic          grad_out_0_last;
`ifdef HARDTANH_BWD_CLIP_COUNT_EN
  logic [3:0]    clip_count;
`endif

  always #5 clk = ~clk;

  hardtanh_backward dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .grad_in_0        (grad_in_0),
    .grad_in_0_valid  (grad_in_0_valid),
    .grad_in_0_ready  (grad_in_0_ready),
    .grad_out_0       (grad_out_0),
    .grad_out_0_valid (grad_out_0_valid),
    .grad_out_0_ready (grad_out_0_ready),
`ifdef HARDTANH_BWD_CLIP_COUNT_EN
    .grad_out_0_last  (grad_out_0_last),
    .clip_count       (clip_count)
`else
    .grad_out_0_last  (grad_out_0_last)
`endif
  );

  typedef struct {
    logic [N-1:0][GW-1:0] g;
    bit                   last;
    int                   clip;
  } beat_t;

  typedef struct {
    bit last;
    int cyc;
    int clip;
  } hs_t;

  typedef struct {
    int x0, x1, g0, g1, e0, e1;
    bit el;
  } vec_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  beat_t exp_q [$];
  hs_t   hs_q  [$];
  int    acc_beats = 0;
  int    clip_acc  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_range(input logic [XW-1:0] x);
    int v;
    v = $signed(x);
    return (v > MINV) && (v < MAXV);
  endfunction

  // Reference: a queue of beats held inside the DUT; readies depend only on its depth.
  always @(negedge clk) begin
    beat_t b;
    int    occ;
    int    nclip;
    int    clip_now;
    cyc++;
    if (!rst) begin
      chk("rst_valid", grad_out_0_valid, 0);
      chk("rst_last", grad_out_0_last, 0);
      chk("rst_dready", data_in_0_ready, 0);
      chk("rst_gready", grad_in_0_ready, 0);
      chk("rst_lane0", grad_out_0[0], 0);
      chk("rst_lane1", grad_out_0[1], 0);
      exp_q.delete();
      acc_beats = 0;
      clip_acc  = 0;
    end else begin
      occ = exp_q.size();
      chk("mon_dready", data_in_0_ready, int'(grad_in_0_valid && occ < 2));
      chk("mon_gready", grad_in_0_ready, int'(data_in_0_valid && occ < 2));
      chk("mon_valid", grad_out_0_valid, int'(occ > 0));
      clip_now = 0;
`ifdef HARDTANH_BWD_CLIP_COUNT_EN
      clip_now = clip_count;
`endif
      if (occ > 0) begin
        for (int i = 0; i < N; i++) chk("mon_lane", grad_out_0[i], exp_q[0].g[i]);
        chk("mon_last", grad_out_0_last, exp_q[0].last);
`ifdef HARDTANH_BWD_CLIP_COUNT_EN
        if (exp_q[0].last) chk("mon_clip", clip_count, exp_q[0].clip);
`endif
        if (grad_out_0_ready) begin
          hs_q.push_back('{grad_out_0_last, cyc, clip_now});
          void'(exp_q.pop_front());
        end
      end
      if (data_in_0_valid && grad_in_0_valid && occ < 2) begin
        nclip = 0;
        for (int i = 0; i < N; i++) begin
          if (in_range(data_in_0[i])) b.g[i] = grad_in_0[i];
          else begin
            b.g[i] = '0;
            nclip++;
          end
        end
        b.last = (acc_beats % BEATS) == BEATS - 1;
        acc_beats++;
        clip_acc += nclip;
        b.clip = clip_acc;
        if (b.last) clip_acc = 0;
        exp_q.push_back(b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int x0, input int x1, input int g0, input int g1);
    data_in_0[0] = 8'(x0);
    data_in_0[1] = 8'(x1);
    grad_in_0[0] = 8'(g0);
    grad_in_0[1] = 8'(g1);
  endtask

  task automatic rand_beat();
    int bnd [6] = '{-64, 64, -63, 63, -65, 65};
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 2) == 0) data_in_0[i] = 8'(bnd[$urandom_range(0, 5)]);
      else data_in_0[i] = 8'($urandom_range(0, 255));
      grad_in_0[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    data_in_0_valid = 1'b0;
    grad_in_0_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    vec_t tbl [6];
    int   sent;
    int   blocked;
    bit   took;
    int   lasts;

    tbl[0] = '{-64, -63, 5, 7, 0, 7, 1'b0};
    tbl[1] = '{63, 64, 9, 3, 9, 0, 1'b0};
    tbl[2] = '{-128, 127, 1, 2, 0, 0, 1'b0};
    tbl[3] = '{0, -1, 128, 255, 128, 255, 1'b1};
    tbl[4] = '{65, -65, 4, 4, 0, 0, 1'b0};
    tbl[5] = '{-20, 30, 11, 22, 11, 22, 1'b0};

    rst = 1'b0;
    data_in_0_valid  = 1'b0;
    grad_in_0_valid  = 1'b0;
    grad_out_0_ready = 1'b1;
    set_beat(0, 0, 0, 0);
    #2;
    chk("init_valid", grad_out_0_valid, 0);
    chk("init_last", grad_out_0_last, 0);
    chk("init_lane0", grad_out_0[0], 0);
    step();
    step();
    rst = 1'b1;

    // Table vectors: one isolated beat each, checked one cycle after accept.
    foreach (tbl[k]) begin
      set_beat(tbl[k].x0, tbl[k].x1, tbl[k].g0, tbl[k].g1);
      data_in_0_valid = 1'b1;
      grad_in_0_valid = 1'b1;
      step();
      data_in_0_valid = 1'b0;
      grad_in_0_valid = 1'b0;
      @(negedge clk);
      chk("tbl_valid", grad_out_0_valid, 1);
      chk("tbl_lane0", grad_out_0[0], tbl[k].e0);
      chk("tbl_lane1", grad_out_0[1], tbl[k].e1);
      chk("tbl_last", grad_out_0_last, tbl[k].el);
      step();
    end

    // Five back-to-back beats with the sink always ready.
    do_reset();
    hs_q.delete();
    for (int k = 0; k < 5; k++) begin
      rand_beat();
      data_in_0_valid = 1'b1;
      grad_in_0_valid = 1'b1;
      step();
    end
    data_in_0_valid = 1'b0;
    grad_in_0_valid = 1'b0;
    step(); step(); step();
    chk("b2b_count", hs_q.size(), 5);
    if (hs_q.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("b2b_last", hs_q[k].last, int'(k == 3));
        chk("b2b_consec", hs_q[k].cyc, hs_q[0].cyc + k);
      end
    end

    // Only the saved-x stream valid: nothing may be consumed.
    do_reset();
    hs_q.delete();
    rand_beat();
    data_in_0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("join_dready", data_in_0_ready, 0);
      chk("join_gready", grad_in_0_ready, 1);
      step();
    end
    data_in_0_valid = 1'b0;
    step();
    chk("join_no_out", hs_q.size(), 0);
    for (int k = 0; k < 4; k++) begin
      rand_beat();
      data_in_0_valid = 1'b1;
      grad_in_0_valid = 1'b1;
      step();
    end
    data_in_0_valid = 1'b0;
    grad_in_0_valid = 1'b0;
    step(); step();
    chk("join_count", hs_q.size(), 4);
    if (hs_q.size() == 4) chk("join_last4", hs_q[3].last, 1);

    // Sink stalls for five cycles while a source streams eight beats.
    do_reset();
    hs_q.delete();
    sent = 0;
    blocked = 0;
    rand_beat();
    for (int c = 0; c < 24; c++) begin
      grad_out_0_ready = !(c >= 2 && c < 7);
      data_in_0_valid  = (sent < 8);
      grad_in_0_valid  = (sent < 8);
      @(negedge clk);
      took = data_in_0_valid && grad_in_0_valid && data_in_0_ready;
      if (data_in_0_valid && grad_in_0_valid && !data_in_0_ready) blocked++;
      step();
      if (took) begin
        sent++;
        rand_beat();
      end
    end
    data_in_0_valid  = 1'b0;
    grad_in_0_valid  = 1'b0;
    grad_out_0_ready = 1'b1;
    step(); step(); step();
    chk("stall_backpressure", int'(blocked > 0), 1);
    chk("stall_sent", sent, 8);
    chk("stall_count", hs_q.size(), 8);
    lasts = 0;
    foreach (hs_q[k]) lasts += hs_q[k].last;
    chk("stall_lasts", lasts, 2);
    if (hs_q.size() == 8) chk("stall_last8", hs_q[7].last, 1);

    // Reset after the second beat of a tensor.
    do_reset();
    grad_out_0_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_beat();
      data_in_0_valid = 1'b1;
      grad_in_0_valid = 1'b1;
      step();
    end
    chk("pre_rst_valid", grad_out_0_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", grad_out_0_valid, 0);
    chk("mid_rst_dready", data_in_0_ready, 0);
    chk("mid_rst_gready", grad_in_0_ready, 0);
    data_in_0_valid = 1'b0;
    grad_in_0_valid = 1'b0;
    step();
    rst = 1'b1;
    grad_out_0_ready = 1'b1;
    hs_q.delete();
    for (int k = 0; k < 4; k++) begin
      rand_beat();
      data_in_0_valid = 1'b1;
      grad_in_0_valid = 1'b1;
      step();
    end
    data_in_0_valid = 1'b0;
    grad_in_0_valid = 1'b0;
    step(); step();
    chk("post_rst_count", hs_q.size(), 4);
    if (hs_q.size() == 4) begin
      chk("post_rst_last3", hs_q[2].last, 0);
      chk("post_rst_last4", hs_q[3].last, 1);
    end

`ifdef HARDTANH_BWD_CLIP_COUNT_EN
    do_reset();
    hs_q.delete();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: set_beat(-128, 0, 1, 1);
        1: set_beat(127, 64, 1, 1);
        2: set_beat(10, -64, 1, 1);
        default: set_beat(1, 2, 1, 1);
      endcase
      data_in_0_valid = 1'b1;
      grad_in_0_valid = 1'b1;
      step();
    end
    data_in_0_valid = 1'b0;
    grad_in_0_valid = 1'b0;
    step(); step();
    chk("clip_count_beats", hs_q.size(), 4);
    if (hs_q.size() == 4) chk("clip_count_total", hs_q[3].clip, 4);
`endif

    // Random traffic on both inputs and the sink against the reference queue.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rand_beat();
      data_in_0_valid  = ($urandom_range(0, 3) != 0);
      grad_in_0_valid  = ($urandom_range(0, 3) != 0);
      grad_out_0_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    data_in_0_valid  = 1'b0;
    grad_in_0_valid  = 1'b0;
    grad_out_0_ready = 1'b1;
    step(); step(); step();
    @(negedge clk);
    chk("final_idle", grad_out_0_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
